// File: rtl/ghostbus_periph.sv
// Ghostbus leaf peripheral: ID, scratch, gated event counter on demo_sig, 64-word RAM.
// Reads are captured at the launch edge and delivered RD edges later through a shift pipeline.
module ghostbus_periph #(
  parameter int AW = 24,
  parameter int DW = 32,
  parameter int GW = 8,
  parameter int RD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        demo_sig,
  input  logic [23:0] GBPORT_addr,
  input  logic [31:0] GBPORT_dout,
  output logic [31:0] GBPORT_din,
  input  logic        GBPORT_we,
  input  logic        GBPORT_wstb,
  input  logic        GBPORT_rstb
);

  localparam logic [31:0] ID_VAL = 32'h600D_BA5E;

  logic [7:0]    w_addr;
  logic          w_wr;
  logic          w_ram_sel;
  logic          w_rise;
  logic          w_clr;
  logic [31:0]   w_rdata;
  logic          w_unused;

  logic [2:0]    r_sync;
  logic [GW-1:0] r_scratch;
  logic          r_en;
  logic [AW-1:0] r_count;
  logic [DW-1:0] r_ram [64];
  logic [31:0]   r_pipe [RD];
  logic [RD-1:0] r_vld;
  logic [31:0]   r_din;

  assign w_addr    = GBPORT_addr[7:0];
  assign w_wr      = GBPORT_we & GBPORT_wstb;
  assign w_ram_sel = (w_addr[7:6] == 2'b01);
  // r_sync[1] is the synchronized level; r_sync[2] is its one-cycle delay for edge detect
  assign w_rise    = r_sync[1] & ~r_sync[2];
  assign w_clr     = w_wr && (w_addr == 8'h02) && GBPORT_dout[1];
  assign w_unused  = ^{GBPORT_addr[23:8], GBPORT_dout};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_scratch <= '0;
      r_en      <= 1'b0;
      r_count   <= '0;
    end else begin
      r_sync <= {r_sync[1:0], demo_sig};
      if (w_wr && (w_addr == 8'h01)) r_scratch <= GBPORT_dout[GW-1:0];
      if (w_wr && (w_addr == 8'h02)) r_en <= GBPORT_dout[0];
      // clear beats a coincident counted edge
      if (w_clr) r_count <= '0;
      else if (r_en && w_rise) r_count <= r_count + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && w_ram_sel) r_ram[w_addr[5:0]] <= GBPORT_dout[DW-1:0];
  end

  always_comb begin
    w_rdata = '0;
    if (w_ram_sel) begin
      w_rdata = 32'(r_ram[w_addr[5:0]]);
    end else begin
      case (w_addr)
        8'h00:   w_rdata = ID_VAL;
        8'h01:   w_rdata = 32'(r_scratch);
        8'h02:   w_rdata = {31'b0, r_en};
        8'h03:   w_rdata = 32'(r_count);
        8'h04:   w_rdata = {31'b0, r_sync[1]};
        default: w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD; i++) r_pipe[i] <= '0;
      r_vld <= '0;
      r_din <= '0;
    end else begin
      r_pipe[0] <= w_rdata;
      r_vld[0]  <= GBPORT_rstb;
      for (int i = 1; i < RD; i++) begin
        r_pipe[i] <= r_pipe[i-1];
        r_vld[i]  <= r_vld[i-1];
      end
      if (r_vld[RD-1]) r_din <= r_pipe[RD-1];
    end
  end

  assign GBPORT_din = r_din;

endmodule

// File: tb/tb_ghostbus_periph.sv
// Directed bench for ghostbus_periph with AW=4, DW=8, GW=8, RD=8.
module tb_ghostbus_periph;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int GW = 8;
  localparam int RD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        demo_sig = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] dout = '0;
  logic [31:0] din;
  logic        we = 1'b0;
  logic        wstb = 1'b0;
  logic        rstb = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  ghostbus_periph #(.AW(AW), .DW(DW), .GW(GW), .RD(RD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .demo_sig    (demo_sig),
    .GBPORT_addr (addr),
    .GBPORT_dout (dout),
    .GBPORT_din  (din),
    .GBPORT_we   (we),
    .GBPORT_wstb (wstb),
    .GBPORT_rstb (rstb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [23:0] a, input logic [31:0] d);
    addr = a; dout = d; we = 1'b1; wstb = 1'b1;
    cyc();
    we = 1'b0; wstb = 1'b0;
  endtask

  task automatic bus_read(input logic [23:0] a, output logic [31:0] d);
    addr = a; rstb = 1'b1;
    cyc();
    rstb = 1'b0;
    repeat (RD) @(posedge clk);
    #1;
    d = din;
  endtask

  task automatic pulse();
    demo_sig = 1'b1;
    repeat (3) cyc();
    demo_sig = 1'b0;
    repeat (3) cyc();
  endtask

  logic [31:0] rd;
  logic [31:0] exp_v;
  logic [23:0] a_v;

  initial begin
    #3;
    check("rst_din_async", din, 32'h0);
    repeat (3) cyc();
    check("rst_din_held", din, 32'h0);
    rst_n = 1'b1;
    cyc();

    // ID with exact latency
    addr = 24'h0; rstb = 1'b1;
    cyc();
    rstb = 1'b0;
    repeat (RD-1) cyc();
    check("id_early", din, 32'h0);
    cyc();
    check("id", din, 32'h600D_BA5E);

    bus_read(24'h01, rd); check("scratch_rst", rd, 32'h0);
    bus_read(24'h02, rd); check("ctrl_rst", rd, 32'h0);
    bus_read(24'h03, rd); check("count_rst", rd, 32'h0);

    bus_write(24'h01, 32'hFFFF_FFA5);
    bus_read(24'h01, rd); check("scratch_trunc", rd, 32'h0000_00A5);

    // write without strobe must not commit
    addr = 24'h01; dout = 32'h11; we = 1'b1; wstb = 1'b0;
    cyc();
    we = 1'b0;
    bus_read(24'h01, rd); check("scratch_no_wstb", rd, 32'h0000_00A5);

    bus_write(24'h00, 32'h1234_5678);
    bus_read(24'h00, rd); check("id_ro", rd, 32'h600D_BA5E);

    // RAM fill then back-to-back reads
    for (int i = 0; i < 64; i++) begin
      a_v = 24'h40 + 24'(i);
      bus_write(a_v, 32'(i) * 32'h11);
    end
    for (int i = 0; i < 64 + RD; i++) begin
      if (i < 64) begin
        addr = 24'h40 + 24'(i);
        rstb = 1'b1;
      end else begin
        rstb = 1'b0;
      end
      cyc();
      if (i >= RD) begin
        exp_v = (32'(i - RD) * 32'h11) & 32'hFF;
        check("ram_b2b", din, exp_v);
      end
    end
    rstb = 1'b0;

    // reserved and unmapped
    bus_write(24'h10, 32'hDEAD);
    bus_write(24'h90, 32'hDEAD);
    bus_read(24'h10, rd); check("unmapped_10", rd, 32'h0);
    bus_read(24'h90, rd); check("reserved_90", rd, 32'h0);
    bus_read(24'h50, rd); check("ram_no_alias", rd, 32'h10);
    bus_read(24'h01, rd); check("scratch_no_alias", rd, 32'h0000_00A5);

    // same-cycle read/write on SCRATCH returns old value
    addr = 24'h01; dout = 32'h3C; we = 1'b1; wstb = 1'b1; rstb = 1'b1;
    cyc();
    we = 1'b0; wstb = 1'b0; rstb = 1'b0;
    repeat (RD) @(posedge clk);
    #1;
    check("rdw_old", din, 32'h0000_00A5);
    bus_read(24'h01, rd); check("rdw_new", rd, 32'h0000_003C);

    // counter
    pulse();
    bus_read(24'h03, rd); check("count_disabled", rd, 32'h0);
    bus_write(24'h02, 32'h1);
    bus_read(24'h02, rd); check("ctrl_en", rd, 32'h1);
    repeat (5) pulse();
    bus_read(24'h03, rd); check("count_5", rd, 32'h5);

    // CLR commits on the same edge the rising edge would be counted
    demo_sig = 1'b1;
    cyc();
    cyc();
    bus_write(24'h02, 32'h3);
    bus_read(24'h04, rd); check("status_hi", rd, 32'h1);
    bus_read(24'h03, rd); check("count_clr_wins", rd, 32'h0);
    bus_read(24'h02, rd); check("ctrl_clr_reads0", rd, 32'h1);
    demo_sig = 1'b0;
    repeat (4) cyc();
    bus_read(24'h04, rd); check("status_lo", rd, 32'h0);

    repeat (17) pulse();
    bus_read(24'h03, rd); check("count_wrap", rd, 32'h1);

    // reset with a read in flight
    addr = 24'h00; rstb = 1'b1;
    cyc();
    rstb = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    check("midread_rst_din", din, 32'h0);
    cyc();
    rst_n = 1'b1;
    repeat (RD + 2) cyc();
    check("midread_discard", din, 32'h0);
    bus_read(24'h01, rd); check("scratch_after_rst", rd, 32'h0);
    bus_read(24'h03, rd); check("count_after_rst", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ghostbus_periph.md
# ghostbus_periph

Bus-attached leaf peripheral for the ghostbus fabric, occupying a 256-word window of the parent's address map. It provides an ID register, a scratch register, a gated event counter on an external input, and a 64-word RAM. Parents place it by forwarding a window-relative address and gating the strobes with their own address-hit. The `submod_foo` and `submod_baz` instances are this block with different parameters.

## Interface

Parameters:
- `AW`, default 24, event-counter width (1..32).
- `DW`, default 32, RAM word width (1..32).
- `GW`, default 8, scratch register width (1..32).
- `RD`, default 8, read latency in cycles (1..8).

Ports:
- `clk`, input, 1, sole clock; the ghostbus interface is also sampled on `clk`.
- `rst_n`, input, 1, asynchronous active-low reset.
- `demo_sig`, input, 1, asynchronous event input.
- `GBPORT_addr`, input, 24, window-relative word address; only bits [7:0] are decoded.
- `GBPORT_dout`, input, 32, write data (bus to peripheral).
- `GBPORT_din`, output, 32, read data (peripheral to bus).
- `GBPORT_we`, input, 1, write enable, already gated by the parent's address-hit.
- `GBPORT_wstb`, input, 1, write strobe.
- `GBPORT_rstb`, input, 1, read strobe, already gated by the parent's address-hit.

## Operation

Memory map, decoded on `addr[7:0]`:
- 0x00 ID: read-only, constant 32'h600D_BA5E.
- 0x01 SCRATCH: read/write, `GW` bits, reset 0.
- 0x02 CTRL: read/write.
  - bit0 EN: counter enable, reset 0.
  - bit1 CLR: write-1 pulse; always reads 0.
- 0x03 COUNT: read-only, `AW` bits, reset 0. Counts rising edges of synchronized `demo_sig` while EN=1 and wraps to 0 past all-ones.
- 0x04 STATUS: read-only. bit0 is the synchronized `demo_sig` level.
- 0x05–0x3F: reads 0; writes ignored.
- 0x40–0x7F: RAM, 64 × `DW`, indexed by `addr[5:0]`.
  - Writes store `dout[DW-1:0]`.
  - Contents are not reset.
- 0x80–0xFF: reserved; reads 0; writes ignored.

Access rules:
- Write: a write commits on a rising `clk` edge when `we & wstb` = 1. Write data is truncated to the target width.
- Read: the read is launched on a rising edge when `rstb` = 1, regardless of `we`.
  - The register or RAM value is captured at that launch edge.
  - The value is zero-extended to 32 bits.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Same-edge CLR and counted edge: CLR wins and the count becomes 0. EN is written in the same access.
- Input `demo_sig` passes through a 2-flop synchronizer. A third register provides edge detection.

## Timing

- Reset (`rst_n` low, asynchronous): SCRATCH, CTRL, COUNT, synchronizer, and read pipeline go to 0. `din` = 0 immediately. Reset release is synchronous to `clk`.
- Read latency:
  - A read launched at edge k drives `din` at edge k+`RD`.
  - `din` holds that value until the next read result arrives.
  - Reads are fully pipelined, one per cycle; no result is dropped.
- Reset mid-read: in-flight reads are discarded and `din` = 0.
- Writes take effect at the commit edge. A read launched one edge later observes the new value.
- COUNT increments on the 3rd `clk` edge after a `demo_sig` rising edge, counted from when `demo_sig` is first sampled high.
- Minimum `demo_sig` high and low time is 2 cycles. Narrower pulses may be missed.

## Test plan

- Reset then ID:
  - Stimulus: hold `rst_n` low, release, then read 0x00 with `RD`=8.
  - Response: `din` = 0 during reset; 32'h600D_BA5E appears exactly 8 edges after the read launch.
- SCRATCH:
  - Stimulus: with `GW`=8, write 0xFFFF_FFA5 to 0x01, then read it back.
  - Response: read returns 0x0000_00A5.
- RAM:
  - Stimulus: with `DW`=8, write 0x40+i ← i·0x11 for i=0..63, then issue back-to-back reads.
  - Response: each read returns the expected byte zero-extended, one result per cycle, in order.
- Counter:
  - Stimulus: write CTRL=1, apply 5 `demo_sig` pulses, read COUNT, then write CTRL=3 in the same cycle as a pulse edge.
  - Response: COUNT reads 5, then 0.
- Counter wrap:
  - Stimulus: with `AW`=4, apply 17 pulses.
  - Response: COUNT reads 1.
- Unmapped/reserved and read-during-write:
  - Stimulus: write 0xDEAD to 0x10 and 0x90, then read both; also issue a same-cycle read/write on 0x01.
  - Response: reserved reads return 0; the same-cycle read returns the old SCRATCH value.
